// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: opcodes, PSW bit positions,
// sequencer states and opcode classification helpers.
package alu_pkg;

    localparam logic [5:0] OP_ADD    = 6'd0;
    localparam logic [5:0] OP_ADD_B  = 6'd1;
    localparam logic [5:0] OP_ADDC   = 6'd2;
    localparam logic [5:0] OP_ADDC_B = 6'd3;
    localparam logic [5:0] OP_SUB    = 6'd4;
    localparam logic [5:0] OP_SUB_B  = 6'd5;
    localparam logic [5:0] OP_SUBC   = 6'd6;
    localparam logic [5:0] OP_SUBC_B = 6'd7;
    localparam logic [5:0] OP_MOV    = 6'd8;
    localparam logic [5:0] OP_MOV_B  = 6'd9;
    localparam logic [5:0] OP_CMP    = 6'd10;
    localparam logic [5:0] OP_CMP_B  = 6'd11;
    localparam logic [5:0] OP_AND    = 6'd12;
    localparam logic [5:0] OP_AND_B  = 6'd13;
    localparam logic [5:0] OP_OR     = 6'd14;
    localparam logic [5:0] OP_OR_B   = 6'd15;
    localparam logic [5:0] OP_XOR    = 6'd16;
    localparam logic [5:0] OP_XOR_B  = 6'd17;
    localparam logic [5:0] OP_BIT    = 6'd18;
    localparam logic [5:0] OP_BIT_B  = 6'd19;
    localparam logic [5:0] OP_BIC    = 6'd20;
    localparam logic [5:0] OP_BIC_B  = 6'd21;
    localparam logic [5:0] OP_RLA    = 6'd22;
    localparam logic [5:0] OP_RLA_B  = 6'd23;
    localparam logic [5:0] OP_RRA    = 6'd24;
    localparam logic [5:0] OP_RRA_B  = 6'd25;
    localparam logic [5:0] OP_RRC    = 6'd26;
    localparam logic [5:0] OP_RRC_B  = 6'd27;

    localparam logic [5:0] OP_LAST   = 6'd27;

    // PSW bit positions
    localparam int PSW_V = 4;
    localparam int PSW_S = 3;
    localparam int PSW_N = 2;
    localparam int PSW_Z = 1;
    localparam int PSW_C = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Opcodes above OP_LAST are reported as errors and never touch state
    function automatic logic op_is_legal(input logic [5:0] op);
        return (op <= OP_LAST);
    endfunction

    // Compare and bit-test only produce flags; everything else writes back
    function automatic logic op_has_wb(input logic [5:0] op);
        return !((op == OP_CMP) || (op == OP_CMP_B) ||
                 (op == OP_BIT) || (op == OP_BIT_B));
    endfunction

    // Sign bit of a value, taken at bit 7 for byte ops and bit 15 for words
    function automatic logic msb_of(input logic [15:0] x, input logic is_byte);
        return is_byte ? x[7] : x[15];
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU. Odd opcodes are byte variants that work on the
// low byte and return a zero upper byte. Flags are only rewritten when
// instr_opt is set; PSW bits above the flag field always pass through.
module alu
    import alu_pkg::*;
(
    input  logic [5:0]  op_code,
    input  logic [15:0] op1,
    input  logic [15:0] op2,
    input  logic        instr_opt,
    input  logic [15:0] PSW_i,
    output logic [15:0] result,
    output logic [15:0] PSW_o
);

    logic        w_byte;
    logic [15:0] w_mask;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [15:0] w_addend;
    logic        w_cin;
    logic [16:0] w_sum;
    logic [15:0] w_res;
    logic        w_c;
    logic        w_v;
    logic        w_flags_upd;
    logic        w_logic_flags;
    logic        w_n;
    logic        w_z;

    // Mask operands to the op width and set up the shared adder; subtraction
    // is done as dst + ~src + carry-in so carry means "no borrow"
    always_comb begin
        w_byte   = op_code[0];
        w_mask   = w_byte ? 16'h00FF : 16'hFFFF;
        w_a      = op1 & w_mask;
        w_b      = op2 & w_mask;
        w_addend = w_b;
        w_cin    = 1'b0;
        case (op_code)
            OP_ADDC, OP_ADDC_B: begin
                w_cin = PSW_i[PSW_C];
            end
            OP_SUB, OP_SUB_B, OP_CMP, OP_CMP_B: begin
                w_addend = ~w_b & w_mask;
                w_cin    = 1'b1;
            end
            OP_SUBC, OP_SUBC_B: begin
                w_addend = ~w_b & w_mask;
                w_cin    = PSW_i[PSW_C];
            end
            default: ;
        endcase
        w_sum = {1'b0, w_a} + {1'b0, w_addend} + {16'h0000, w_cin};
    end

    // Select the result and the carry/overflow for each operation class
    always_comb begin
        w_res         = 16'h0000;
        w_c           = PSW_i[PSW_C];
        w_v           = PSW_i[PSW_V];
        w_flags_upd   = 1'b0;
        w_logic_flags = 1'b0;
        case (op_code)
            OP_ADD, OP_ADD_B, OP_ADDC, OP_ADDC_B,
            OP_SUB, OP_SUB_B, OP_SUBC, OP_SUBC_B,
            OP_CMP, OP_CMP_B: begin
                w_res       = w_sum[15:0] & w_mask;
                w_c         = w_byte ? w_sum[8] : w_sum[16];
                w_v         = (msb_of(w_a, w_byte) == msb_of(w_addend, w_byte)) &&
                              (msb_of(w_res, w_byte) != msb_of(w_a, w_byte));
                w_flags_upd = 1'b1;
            end
            OP_MOV, OP_MOV_B: begin
                w_res = w_b;
            end
            OP_AND, OP_AND_B, OP_BIT, OP_BIT_B: begin
                w_res         = w_a & w_b;
                w_logic_flags = 1'b1;
            end
            OP_OR, OP_OR_B: begin
                w_res         = w_a | w_b;
                w_logic_flags = 1'b1;
            end
            OP_XOR, OP_XOR_B: begin
                w_res         = w_a ^ w_b;
                w_logic_flags = 1'b1;
            end
            OP_BIC, OP_BIC_B: begin
                w_res         = w_a & ~w_b;
                w_logic_flags = 1'b1;
            end
            OP_RLA, OP_RLA_B: begin
                w_res       = {w_a[14:0], 1'b0} & w_mask;
                w_c         = msb_of(w_a, w_byte);
                w_v         = msb_of(w_a, w_byte) ^ (w_byte ? w_a[6] : w_a[14]);
                w_flags_upd = 1'b1;
            end
            OP_RRA, OP_RRA_B: begin
                w_res       = w_byte ? {8'h00, w_a[7], w_a[7:1]} : {w_a[15], w_a[15:1]};
                w_c         = w_a[0];
                w_v         = 1'b0;
                w_flags_upd = 1'b1;
            end
            OP_RRC, OP_RRC_B: begin
                w_res       = w_byte ? {8'h00, PSW_i[PSW_C], w_a[7:1]}
                                     : {PSW_i[PSW_C], w_a[15:1]};
                w_c         = w_a[0];
                w_v         = 1'b0;
                w_flags_upd = 1'b1;
            end
            default: ;
        endcase
        if (w_logic_flags) begin
            w_c         = |w_res;
            w_v         = 1'b0;
            w_flags_upd = 1'b1;
        end
    end

    // Assemble the outgoing PSW; S is the signed-less-than flag N xor V
    always_comb begin
        w_n    = msb_of(w_res, w_byte);
        w_z    = (w_res == 16'h0000);
        result = w_res;
        PSW_o  = PSW_i;
        if (w_flags_upd && instr_opt) begin
            PSW_o[PSW_V] = w_v;
            PSW_o[PSW_S] = w_n ^ w_v;
            PSW_o[PSW_N] = w_n;
            PSW_o[PSW_Z] = w_z;
            PSW_o[PSW_C] = w_c;
        end
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: accepts one op from decode, runs it through the
// ALU for one cycle, commits flags into the PSW it owns and hands the result
// to the register file over a valid/ready handshake.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter logic [15:0] PSW_RST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [15:0] req_dst,
    input  logic [15:0] req_src,
    input  logic [2:0]  req_reg,
    input  logic        req_psw_upd,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [2:0]  wb_reg,
    output logic [15:0] wb_data,
    output logic [15:0] psw,
    input  logic        psw_wr_en,
    input  logic [15:0] psw_wr_data,
    output logic        done,
    output logic        err
);

    state_t      r_state;
    state_t      w_next_state;

    logic [5:0]  r_op;
    logic [15:0] r_dst;
    logic [15:0] r_src;
    logic [2:0]  r_reg;
    logic        r_upd;

    logic [15:0] r_psw;
    logic        r_wb_valid;
    logic [2:0]  r_wb_reg;
    logic [15:0] r_wb_data;
    logic        r_done;
    logic        r_err;

    logic [15:0] w_alu_result;
    logic [15:0] w_alu_psw;
    logic        w_unused_psw_hi;

    logic        w_accept;
    logic        w_in_exec;
    logic        w_op_legal;
    logic        w_op_wb;
    logic        w_wb_fire;

    alu u_alu (
        .op_code   (r_op),
        .op1       (r_dst),
        .op2       (r_src),
        .instr_opt (r_upd),
        .PSW_i     (r_psw),
        .result    (w_alu_result),
        .PSW_o     (w_alu_psw)
    );

    // The ALU passes the upper PSW through; only the flag field is taken back
    assign w_unused_psw_hi = &{1'b0, w_alu_psw[15:5]};

    assign w_op_legal = op_is_legal(r_op);
    assign w_op_wb    = w_op_legal && op_has_wb(r_op);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: EXEC always lasts exactly one cycle, WB waits for the sink
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_next_state = S_EXEC;
            S_EXEC: w_next_state = w_op_wb ? S_WB : S_IDLE;
            S_WB:   if (wb_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake decode; req_ready looks only at state and reset, never at req_valid
    always_comb begin
        req_ready = rst_n && (r_state == S_IDLE);
        w_accept  = req_ready && req_valid;
        w_in_exec = (r_state == S_EXEC);
        w_wb_fire = (r_state == S_WB) && wb_ready;
    end

    // Capture the request so the ALU sees stable operands through EXEC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op  <= 6'd0;
            r_dst <= 16'h0000;
            r_src <= 16'h0000;
            r_reg <= 3'd0;
            r_upd <= 1'b0;
        end else if (w_accept) begin
            r_op  <= req_op;
            r_dst <= req_dst;
            r_src <= req_src;
            r_reg <= req_reg;
            r_upd <= req_psw_upd;
        end
    end

    // PSW: an external load beats the ALU commit; illegal ops leave it alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_psw <= PSW_RST;
        end else if (psw_wr_en) begin
            r_psw <= psw_wr_data;
        end else if (w_in_exec && w_op_legal) begin
            r_psw <= {r_psw[15:5], w_alu_psw[4:0]};
        end
    end

    // Writeback register holds result and index steady until the sink takes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_reg   <= 3'd0;
            r_wb_data  <= 16'h0000;
        end else if (w_in_exec) begin
            r_wb_valid <= w_op_wb;
            r_wb_reg   <= r_reg;
            r_wb_data  <= w_alu_result;
        end else if (w_wb_fire) begin
            r_wb_valid <= 1'b0;
        end
    end

    // Retirement pulses: flag-only and illegal ops retire out of EXEC,
    // writeback ops retire on the handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= (w_in_exec && !w_op_wb) || w_wb_fire;
            r_err  <= w_in_exec && !w_op_legal;
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_reg   = r_wb_reg;
    assign wb_data  = r_wb_data;
    assign psw      = r_psw;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_alu_exec_ctrl;

    localparam logic [15:0] PSW_RST = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [15:0] req_dst;
    logic [15:0] req_src;
    logic [2:0]  req_reg;
    logic        req_psw_upd;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic [15:0] psw;
    logic        psw_wr_en;
    logic [15:0] psw_wr_data;
    logic        done;
    logic        err;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;

    // Model state: where the current op is in its life, plus expected outputs
    int          mPhase = 0;
    logic [5:0]  mOp;
    logic [15:0] mDst;
    logic [15:0] mSrc;
    logic [2:0]  mReg;
    bit          mUpd;
    logic [15:0] mPsw = PSW_RST;
    bit          mWbValid = 1'b0;
    logic [2:0]  mWbReg = 3'd0;
    logic [15:0] mWbData = 16'h0000;
    bit          mDone = 1'b0;
    bit          mErr = 1'b0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.PSW_RST(PSW_RST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_dst     (req_dst),
        .req_src     (req_src),
        .req_reg     (req_reg),
        .req_psw_upd (req_psw_upd),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .psw         (psw),
        .psw_wr_en   (psw_wr_en),
        .psw_wr_data (psw_wr_data),
        .done        (done),
        .err         (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from signed/unsigned arithmetic on plain integers
    function automatic void refAlu(input int op, input int dst, input int src,
                                   input logic [15:0] pswIn, input bit upd,
                                   output int res, output logic [4:0] flags,
                                   output bit legal, output bit hasWb);
        int w, mask, sgn, a, b, cin, sa, sb, sr, brw, fam;
        bit n, v, c, touch, logicOp;
        legal = (op <= 27);
        hasWb = legal && !(op == 10 || op == 11 || op == 18 || op == 19);
        flags = pswIn[4:0];
        res   = 0;
        if (!legal) return;
        w    = (op % 2 == 1) ? 8 : 16;
        mask = (1 << w) - 1;
        sgn  = 1 << (w - 1);
        a    = dst & mask;
        b    = src & mask;
        cin  = int'(pswIn[0]);
        sa   = (a >= sgn) ? a - (mask + 1) : a;
        sb   = (b >= sgn) ? b - (mask + 1) : b;
        c = pswIn[0];
        v = pswIn[4];
        touch = 1'b1;
        logicOp = 1'b0;
        fam = op / 2;
        case (fam)
            0, 1: begin
                brw = (fam == 1) ? cin : 0;
                res = (a + b + brw) & mask;
                c   = (a + b + brw) > mask;
                sr  = sa + sb + brw;
                v   = (sr > sgn - 1) || (sr < -sgn);
            end
            2, 3, 5: begin
                brw = (fam == 3) ? 1 - cin : 0;
                res = (a - b - brw) & mask;
                c   = (a - b - brw) >= 0;
                sr  = sa - sb - brw;
                v   = (sr > sgn - 1) || (sr < -sgn);
            end
            4:     begin res = b; touch = 1'b0; end
            6, 9:  begin res = a & b; logicOp = 1'b1; end
            7:     begin res = a | b; logicOp = 1'b1; end
            8:     begin res = a ^ b; logicOp = 1'b1; end
            10:    begin res = a & ~b & mask; logicOp = 1'b1; end
            11: begin
                res = (a * 2) & mask;
                c   = a >= sgn;
                sr  = sa * 2;
                v   = (sr > sgn - 1) || (sr < -sgn);
            end
            12: begin res = (sa >>> 1) & mask; c = (a % 2) == 1; v = 1'b0; end
            default: begin res = (a >> 1) | (cin != 0 ? sgn : 0); c = (a % 2) == 1; v = 1'b0; end
        endcase
        if (logicOp) begin
            c = (res != 0);
            v = 1'b0;
        end
        if (touch && upd) begin
            n = (res >= sgn);
            flags = {v, n ^ v, n, (res == 0), c};
        end
    endfunction

    // Behavioural model of the op lifecycle, stepped on each rising edge
    always @(posedge clk) begin : modelStep
        int res;
        logic [4:0] fl;
        bit lg, hw;
        if (!rst_n) begin
            mPhase = 0; mPsw = PSW_RST; mWbValid = 1'b0; mWbReg = 3'd0;
            mWbData = 16'h0000; mDone = 1'b0; mErr = 1'b0;
        end else begin
            mDone = 1'b0;
            mErr  = 1'b0;
            if (mPhase == 0) begin
                if (req_valid) begin
                    mOp = req_op; mDst = req_dst; mSrc = req_src;
                    mReg = req_reg; mUpd = req_psw_upd; mPhase = 1;
                end
            end else if (mPhase == 1) begin
                refAlu(int'(mOp), int'(mDst), int'(mSrc), mPsw, mUpd, res, fl, lg, hw);
                if (!lg) begin
                    mDone = 1'b1; mErr = 1'b1; mPhase = 0;
                end else begin
                    mPsw[4:0] = fl;
                    if (hw) begin
                        mWbValid = 1'b1; mWbData = res[15:0]; mWbReg = mReg; mPhase = 2;
                    end else begin
                        mDone = 1'b1; mPhase = 0;
                    end
                end
            end else if (wb_ready) begin
                mWbValid = 1'b0; mDone = 1'b1; mPhase = 0;
            end
            if (psw_wr_en) mPsw = psw_wr_data;
        end
    end

    // Compare DUT against the model every cycle, away from the rising edge
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("req_ready", req_ready, rst_n && (mPhase == 0));
            checkOutput("wb_valid", wb_valid, mWbValid);
            if (mWbValid) begin
                checkOutput("wb_reg", wb_reg, mWbReg);
                checkOutput("wb_data", wb_data, mWbData);
            end
            checkOutput("psw", psw, mPsw);
            checkOutput("done", done, mDone);
            checkOutput("err", err, mErr);
        end
    end

    task automatic applyStimulus(input bit v, input logic [5:0] op, input logic [15:0] d,
                                 input logic [15:0] s, input logic [2:0] r, input bit u);
        req_valid = v; req_op = op; req_dst = d; req_src = s; req_reg = r; req_psw_upd = u;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int res;
        logic [4:0] fl;
        bit lg, hw;

        rst_n = 1'b0; wb_ready = 1'b0; psw_wr_en = 1'b0; psw_wr_data = 16'h0000;
        applyStimulus(1'b0, 6'd0, 16'h0000, 16'h0000, 3'd0, 1'b0);

        // Pin the reference ALU to hand-computed values
        refAlu(0, 16'h0005, 16'h0003, 16'h0000, 1'b1, res, fl, lg, hw);
        checkOutput("model add res", res, 32'h8);
        checkOutput("model add flags", fl, 32'h0);
        refAlu(0, 16'h7FFF, 16'h0001, 16'h0000, 1'b1, res, fl, lg, hw);
        checkOutput("model ovf res", res, 32'h8000);
        checkOutput("model ovf flags", fl, 32'h14);
        refAlu(10, 16'h0005, 16'h0005, 16'h0000, 1'b1, res, fl, lg, hw);
        checkOutput("model cmp flags", fl, 32'h03);
        checkOutput("model cmp haswb", hw, 32'h0);
        refAlu(4, 16'h0000, 16'h0001, 16'h0000, 1'b1, res, fl, lg, hw);
        checkOutput("model sub res", res, 32'hFFFF);
        checkOutput("model sub flags", fl, 32'h0C);
        refAlu(27, 16'h0181, 16'h0000, 16'h0001, 1'b1, res, fl, lg, hw);
        checkOutput("model rrcb res", res, 32'hC0);
        checkOutput("model rrcb flags", fl, 32'h0D);

        // Reset state
        tick();
        checkEn = 1'b1;
        checkOutput("rst req_ready", req_ready, 32'h0);
        checkOutput("rst psw", psw, PSW_RST);
        checkOutput("rst wb_valid", wb_valid, 32'h0);
        checkOutput("rst done", done, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("idle req_ready", req_ready, 32'h1);

        // add with backpressure
        applyStimulus(1'b1, 6'd0, 16'h0005, 16'h0003, 3'd3, 1'b1);
        tick();
        req_valid = 1'b0;
        checkOutput("exec req_ready", req_ready, 32'h0);
        tick();
        checkOutput("add wb_valid", wb_valid, 32'h1);
        checkOutput("add wb_data", wb_data, 32'h8);
        checkOutput("add wb_reg", wb_reg, 32'h3);
        checkOutput("add flags", psw[4:0], 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp wb_valid", wb_valid, 32'h1);
            checkOutput("bp wb_data", wb_data, 32'h8);
            checkOutput("bp wb_reg", wb_reg, 32'h3);
            checkOutput("bp req_ready", req_ready, 32'h0);
            checkOutput("bp done", done, 32'h0);
        end
        wb_ready = 1'b1;
        tick();
        checkOutput("bp done pulse", done, 32'h1);
        checkOutput("bp wb_valid drop", wb_valid, 32'h0);
        tick();
        checkOutput("bp done width", done, 32'h0);

        // Overflow keeps the preset upper PSW bits
        psw_wr_en = 1'b1; psw_wr_data = 16'h00E0;
        tick();
        psw_wr_en = 1'b0;
        checkOutput("preset psw", psw, 32'hE0);
        applyStimulus(1'b1, 6'd0, 16'h7FFF, 16'h0001, 3'd5, 1'b1);
        tick();
        req_valid = 1'b0;
        tick();
        checkOutput("ovf wb_data", wb_data, 32'h8000);
        checkOutput("ovf psw", psw, 32'hF4);
        tick();

        // cmp: flags only
        applyStimulus(1'b1, 6'd10, 16'h0005, 16'h0005, 3'd1, 1'b1);
        tick();
        req_valid = 1'b0;
        tick();
        checkOutput("cmp wb_valid", wb_valid, 32'h0);
        checkOutput("cmp done", done, 32'h1);
        checkOutput("cmp psw", psw, 32'hE3);
        checkOutput("cmp req_ready", req_ready, 32'h1);

        // External PSW write during EXEC wins
        applyStimulus(1'b1, 6'd0, 16'h0001, 16'h0002, 3'd2, 1'b1);
        tick();
        req_valid = 1'b0; psw_wr_en = 1'b1; psw_wr_data = 16'h00A5;
        tick();
        psw_wr_en = 1'b0;
        checkOutput("coll psw", psw, 32'hA5);
        checkOutput("coll wb_data", wb_data, 32'h3);
        tick();

        // Illegal opcode
        applyStimulus(1'b1, 6'd40, 16'h1234, 16'h5678, 3'd4, 1'b1);
        tick();
        req_valid = 1'b0;
        tick();
        checkOutput("ill err", err, 32'h1);
        checkOutput("ill done", done, 32'h1);
        checkOutput("ill wb_valid", wb_valid, 32'h0);
        checkOutput("ill psw", psw, 32'hA5);
        tick();
        checkOutput("ill err width", err, 32'h0);

        // Reset during WB
        wb_ready = 1'b0;
        applyStimulus(1'b1, 6'd0, 16'h000A, 16'h0014, 3'd6, 1'b1);
        tick();
        req_valid = 1'b0;
        tick();
        checkOutput("wb before rst", wb_valid, 32'h1);
        rst_n = 1'b0;
        tick();
        checkOutput("rst wb_valid", wb_valid, 32'h0);
        checkOutput("rst psw after", psw, PSW_RST);
        checkOutput("rst ready low", req_ready, 32'h0);
        rst_n = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(28, 63)) : 6'($urandom_range(0, 27));
            applyStimulus(1'($urandom_range(0, 1)), op,
                          ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom),
                          ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'($urandom),
                          3'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0));
            wb_ready    = ($urandom_range(0, 3) != 0);
            psw_wr_en   = ($urandom_range(0, 19) == 0);
            psw_wr_data = 16'($urandom);
            rst_n       = ($urandom_range(0, 49) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
